// File: rtl/impulse_scheduler.sv
// -----------------------------------------------------------------------------
// impulse_scheduler
//
// Shares one 16-bit status word between N_CH asynchronous impulse sources.
// Each source's rising edge latches a pending request. Pending requests are
// granted round-robin. A granted burst drives imp to 16'hFFFF for HOLD_MS
// millisecond ticks. It is then followed by GAP_MS ticks of forced idle.
//
// Ports
//   clock     in   system clock (1 MHz)
//   reset     in   asynchronous, active-high reset
//   msec      in   millisecond square wave in the clock domain; a tick is
//                  counted on each rising edge
//   enable    in   allows a new grant to start from IDLE
//   impuls    in   [N_CH] asynchronous impulse requests
//   imp       out  [16] 16'hFFFF while a burst is held, else 0
//   ch_id     out  [3]  channel that owns the current or last burst
//   active    out  high while a burst is held
//   pending   out  [N_CH] latched requests not yet served
//   miss_cnt  out  [8]  saturating count of edges that hit an already-pending
//                  channel
// -----------------------------------------------------------------------------
module impulse_scheduler #(
    parameter int N_CH    = 4,
    parameter int HOLD_MS = 10,
    parameter int GAP_MS  = 1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            msec,
    input  logic            enable,
    input  logic [N_CH-1:0] impuls,
    output logic [15:0]     imp,
    output logic [2:0]      ch_id,
    output logic            active,
    output logic [N_CH-1:0] pending,
    output logic [7:0]      miss_cnt
);

    typedef enum logic [1:0] {IDLE, GRANT, HOLD, GAP} state_t;

    state_t          state_q, state_d;
    logic [N_CH-1:0] sync1_q, sync2_q, edge_q;
    logic            msec_q;
    logic [N_CH-1:0] pending_q, pending_d;
    logic [7:0]      miss_cnt_q, miss_cnt_d;
    logic [3:0]      ms_cnt_q, ms_cnt_d;
    logic [2:0]      ch_id_q, ch_id_d;
    logic [2:0]      last_ch_q, last_ch_d;
    logic            active_q, active_d;

    logic            tick;
    logic [N_CH-1:0] rise;
    logic [N_CH-1:0] clr;
    logic [N_CH-1:0] miss_vec;
    logic [7:0]      pend_ext;
    logic [7:0]      grant_mask;
    logic [3:0]      rr_idx;
    logic [2:0]      sel;
    logic            found;
    logic [3:0]      miss_num;
    logic [8:0]      miss_sum;

    assign tick = msec & ~msec_q;
    assign rise = sync2_q & ~edge_q;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge value of every other flop.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            sync1_q    <= '0;
            sync2_q    <= '0;
            edge_q     <= '0;
            msec_q     <= 1'b0;
            pending_q  <= '0;
            miss_cnt_q <= '0;
            ms_cnt_q   <= '0;
            ch_id_q    <= '0;
            last_ch_q  <= 3'(N_CH - 1);
            active_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync1_q    <= impuls;
            sync2_q    <= sync1_q;
            edge_q     <= sync2_q;
            msec_q     <= msec;
            pending_q  <= pending_d;
            miss_cnt_q <= miss_cnt_d;
            ms_cnt_q   <= ms_cnt_d;
            ch_id_q    <= ch_id_d;
            last_ch_q  <= last_ch_d;
            active_q   <= active_d;
        end
    end

    // NOTE: every variable written here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        ms_cnt_d   = ms_cnt_q;
        ch_id_d    = ch_id_q;
        last_ch_d  = last_ch_q;
        active_d   = active_q;
        grant_mask = '0;

        // Round-robin search starting at last_ch+1. The loop runs from the
        // farthest candidate to the nearest. The last hit therefore wins,
        // which gives it the lowest rotated distance.
        pend_ext = 8'(pending_q);
        sel      = last_ch_q;
        found    = 1'b0;
        rr_idx   = '0;
        for (int k = N_CH; k >= 1; k--) begin
            rr_idx = {1'b0, last_ch_q} + 4'(k);
            if (rr_idx >= 4'(N_CH)) begin
                rr_idx = rr_idx - 4'(N_CH);
            end
            if (pend_ext[rr_idx[2:0]]) begin
                sel   = rr_idx[2:0];
                found = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (enable && (|pending_q)) begin
                    state_d = GRANT;
                end
            end
            GRANT: begin
                // A tick that lands in this cycle is deliberately ignored.
                if (found) begin
                    grant_mask[sel] = 1'b1;
                    ch_id_d         = sel;
                    last_ch_d       = sel;
                    active_d        = 1'b1;
                    ms_cnt_d        = '0;
                    state_d         = HOLD;
                end else begin
                    state_d = IDLE;
                end
            end
            HOLD: begin
                if (tick) begin
                    if (ms_cnt_q + 4'd1 == 4'(HOLD_MS)) begin
                        active_d = 1'b0;
                        ms_cnt_d = '0;
                        state_d  = (GAP_MS == 0) ? IDLE : GAP;
                    end else begin
                        ms_cnt_d = ms_cnt_q + 4'd1;
                    end
                end
            end
            GAP: begin
                if (tick) begin
                    if (ms_cnt_q + 4'd1 == 4'(GAP_MS)) begin
                        ms_cnt_d = '0;
                        state_d  = IDLE;
                    end else begin
                        ms_cnt_d = ms_cnt_q + 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A new edge outranks the grant clear on the same channel. Such an
        // edge is a fresh request, so it does not count as a miss.
        clr       = grant_mask[N_CH-1:0];
        miss_vec  = rise & pending_q & ~clr;
        pending_d = (pending_q & ~clr) | rise;

        miss_num = '0;
        for (int i = 0; i < N_CH; i++) begin
            miss_num = miss_num + {3'b000, miss_vec[i]};
        end
        miss_sum   = {1'b0, miss_cnt_q} + {5'b00000, miss_num};
        miss_cnt_d = (miss_sum > 9'd255) ? 8'hFF : miss_sum[7:0];
    end

    assign imp      = {16{active_q}};
    assign active   = active_q;
    assign ch_id    = ch_id_q;
    assign pending  = pending_q;
    assign miss_cnt = miss_cnt_q;

endmodule

// File: tb/tb_impulse_scheduler.sv
// -----------------------------------------------------------------------------
// tb_impulse_scheduler
//
// Directed self-checking bench for impulse_scheduler. It uses the default
// parameters (N_CH=4, HOLD_MS=10, GAP_MS=1). Inputs are driven on the falling
// clock edge. Outputs are sampled on the falling edge, half a cycle after the
// active rising edge. msec is driven as single rising edges from ms_tick.
// -----------------------------------------------------------------------------
`timescale 1ns / 1ps

module tb_impulse_scheduler;

    localparam int N_CH = 4;
    localparam int HOLD = 10;
    localparam int GAP  = 1;

    logic            clock;
    logic            reset;
    logic            msec;
    logic            enable;
    logic [N_CH-1:0] impuls;
    logic [15:0]     imp;
    logic [2:0]      ch_id;
    logic            active;
    logic [N_CH-1:0] pending;
    logic [7:0]      miss_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    impulse_scheduler #(
        .N_CH    (N_CH),
        .HOLD_MS (HOLD),
        .GAP_MS  (GAP)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .msec     (msec),
        .enable   (enable),
        .impuls   (impuls),
        .imp      (imp),
        .ch_id    (ch_id),
        .active   (active),
        .pending  (pending),
        .miss_cnt (miss_cnt)
    );

    initial clock = 1'b0;
    always #500 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        msec   = 1'b0;
        enable = 1'b1;
        impuls = '0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
    endtask

    // One-cycle-high pulse followed by one low cycle, so that back-to-back
    // calls still produce distinct rising edges.
    task automatic pulse(input logic [N_CH-1:0] mask);
        impuls = mask;
        @(negedge clock);
        impuls = '0;
        @(negedge clock);
    endtask

    // One msec rising edge. It is seen at the first rising clock edge.
    task automatic ms_tick();
        msec = 1'b1;
        @(negedge clock);
        msec = 1'b0;
        @(negedge clock);
    endtask

    // Called in the first HOLD cycles of a burst. It runs the burst and the
    // gap to completion. On return, the scheduler is in GRANT if more requests
    // are pending and enable=1, and in IDLE otherwise.
    task automatic burst(input string tag, input logic [2:0] ch, input logic [N_CH-1:0] pend);
        check({tag, ":imp_on"},  32'(imp),     'hFFFF);
        check({tag, ":ch_id"},   32'(ch_id),   32'(ch));
        check({tag, ":active"},  32'(active),  1);
        check({tag, ":pending"}, 32'(pending), 32'(pend));
        repeat (HOLD - 1) ms_tick();
        check({tag, ":imp_before_last_tick"}, 32'(imp), 'hFFFF);
        ms_tick();
        check({tag, ":imp_off"},    32'(imp),    0);
        check({tag, ":active_off"}, 32'(active), 0);
        check({tag, ":ch_id_kept"}, 32'(ch_id),  32'(ch));
        repeat (3) @(negedge clock);
        check({tag, ":gap_idle"}, 32'(imp), 0);
        ms_tick();
    endtask

    initial begin
        // ---------------- reset state ----------------
        reset  = 1'b1;
        msec   = 1'b0;
        enable = 1'b1;
        impuls = '0;
        repeat (2) @(negedge clock);
        check("rst:imp",      32'(imp),      0);
        check("rst:active",   32'(active),   0);
        check("rst:ch_id",    32'(ch_id),    0);
        check("rst:pending",  32'(pending),  0);
        check("rst:miss_cnt", 32'(miss_cnt), 0);
        reset = 1'b0;
        @(negedge clock);

        // ---------------- single pulse on channel 2 ----------------
        pulse(4'b0100);
        check("A:pending_not_yet", 32'(pending), 0);
        @(negedge clock);
        check("A:pending_set", 32'(pending), 'b0100);
        @(negedge clock);
        check("A:grant_imp_low", 32'(imp), 0);
        // This tick lands in the GRANT cycle and must not be counted.
        msec = 1'b1;
        @(negedge clock);
        msec = 1'b0;
        check("A:imp_on_2_after_pending", 32'(imp), 'hFFFF);
        @(negedge clock);
        burst("A", 3'd2, 4'b0000);
        repeat (3) @(negedge clock);
        check("A:idle_after", 32'(imp), 0);
        check("A:ch_id_retained", 32'(ch_id), 2);

        // ---------------- channels 0,1,3 together ----------------
        do_reset();
        pulse(4'b1011);
        @(negedge clock);
        check("B:pending", 32'(pending), 'b1011);
        @(negedge clock);
        @(negedge clock);
        burst("B0", 3'd0, 4'b1010);
        @(negedge clock);
        burst("B1", 3'd1, 4'b1000);
        @(negedge clock);
        burst("B3", 3'd3, 4'b0000);
        check("B:miss_cnt", 32'(miss_cnt), 0);

        // ---------------- repeat pulses on channel 1 during channel 0 hold ----------------
        do_reset();
        pulse(4'b0001);
        repeat (3) @(negedge clock);
        check("C:hold_ch0", 32'(imp), 'hFFFF);
        pulse(4'b0010);
        pulse(4'b0010);
        pulse(4'b0010);
        repeat (2) @(negedge clock);
        check("C:pending1", 32'(pending),  'b0010);
        check("C:miss2",    32'(miss_cnt), 2);
        burst("C0", 3'd0, 4'b0010);
        @(negedge clock);
        burst("C1", 3'd1, 4'b0000);
        repeat (5) @(negedge clock);
        check("C:no_second_burst", 32'(imp), 0);
        check("C:pending_empty",   32'(pending), 0);

        // ---------------- enable=0 blocks grants ----------------
        do_reset();
        enable = 1'b0;
        pulse(4'b1111);
        @(negedge clock);
        check("D:pending_all", 32'(pending), 'hF);
        ms_tick();
        ms_tick();
        repeat (4) @(negedge clock);
        check("D:imp_blocked",    32'(imp),    0);
        check("D:active_blocked", 32'(active), 0);
        enable = 1'b1;
        @(negedge clock);
        check("D:grant_cycle", 32'(imp), 0);
        @(negedge clock);
        burst("D0", 3'd0, 4'b1110);
        @(negedge clock);
        burst("D1", 3'd1, 4'b1100);
        @(negedge clock);
        burst("D2", 3'd2, 4'b1000);
        @(negedge clock);
        burst("D3", 3'd3, 4'b0000);

        // ---------------- reset during HOLD ----------------
        do_reset();
        pulse(4'b0001);
        repeat (3) @(negedge clock);
        pulse(4'b0110);
        @(negedge clock);
        check("E:pending_before", 32'(pending), 'b0110);
        check("E:imp_before",     32'(imp),     'hFFFF);
        #100;
        reset = 1'b1;
        #1;
        check("E:imp_async",     32'(imp),     0);
        check("E:active_async",  32'(active),  0);
        check("E:pending_async", 32'(pending), 0);
        @(negedge clock);
        reset = 1'b0;
        repeat (8) @(negedge clock);
        check("E:no_burst",    32'(imp),     0);
        check("E:no_pending",  32'(pending), 0);
        pulse(4'b0010);
        @(negedge clock);
        check("E:new_pending", 32'(pending), 'b0010);
        repeat (2) @(negedge clock);
        check("E:new_burst_imp", 32'(imp),   'hFFFF);
        check("E:new_burst_ch",  32'(ch_id), 1);

        // ---------------- miss counter saturation ----------------
        do_reset();
        enable = 1'b0;
        pulse(4'b0001);
        repeat (254) pulse(4'b0001);
        repeat (2) @(negedge clock);
        check("F:miss_254", 32'(miss_cnt), 254);
        pulse(4'b0001);
        repeat (2) @(negedge clock);
        check("F:miss_255", 32'(miss_cnt), 255);
        repeat (45) pulse(4'b0001);
        repeat (2) @(negedge clock);
        check("F:miss_sat",   32'(miss_cnt), 255);
        check("F:pending_on", 32'(pending),  'b0001);
        check("F:imp_off",    32'(imp),      0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
